// File: rtl/fetch_arbiter.sv
// Round-robin arbiter that hands the single tile-fetch engine to one of three
// requesters (weights, bias, inputs) and guards each fetch with a watchdog.
module fetch_arbiter #(
    parameter int                   TIMEOUT_W   = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 16'hFFFF,
    parameter logic [2:0]           SEL_W       = 3'd0,
    parameter logic [2:0]           SEL_B       = 3'd1,
    parameter logic [2:0]           SEL_I       = 3'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] req_tiles_ctrl,
    input  logic [2:0] req_rst_addr,
    input  logic       fetch_done,
    input  logic       err_clr,
    output logic [2:0] grant,
    output logic [2:0] done,
    output logic       start_fetch,
    output logic       reset_addr_counter,
    output logic [2:0] Buffer_Select,
    output logic       Tiles_Control,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WD_ZERO = {TIMEOUT_W{1'b0}};
    localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    // Last WAIT cycle: the counter reaches TIMEOUT_MAX on the following edge.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_MAX - WD_ONE;

    state_t               state_r, state_next_s;
    logic [1:0]           rr_ptr_r, rr_ptr_next_s;
    logic [TIMEOUT_W-1:0] wd_r, wd_next_s;
    logic [2:0]           grant_r, grant_next_s;
    logic [2:0]           done_r, done_next_s;
    logic                 start_fetch_r, start_fetch_next_s;
    logic                 rac_r, rac_next_s;
    logic [2:0]           bsel_r, bsel_next_s;
    logic                 tiles_r, tiles_next_s;
    logic                 busy_r, busy_next_s;
    logic                 terr_r, terr_next_s;

    logic [1:0]           cand0_s, cand1_s, cand2_s;
    logic [1:0]           win_idx_s;
    logic                 win_valid_s;

    function automatic logic [1:0] inc_mod3(input logic [1:0] v);
        case (v)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] buf_code(input logic [1:0] idx);
        case (idx)
            2'd0:    return SEL_W;
            2'd1:    return SEL_B;
            2'd2:    return SEL_I;
            default: return SEL_W;
        endcase
    endfunction

    // Round-robin search starting at rr_ptr; a corrupted pointer folds back to 0.
    always_comb begin
        cand0_s     = (rr_ptr_r == 2'd3) ? 2'd0 : rr_ptr_r;
        cand1_s     = inc_mod3(cand0_s);
        cand2_s     = inc_mod3(cand1_s);
        win_valid_s = 1'b1;
        win_idx_s   = cand0_s;
        if (req[cand0_s]) begin
            win_idx_s = cand0_s;
        end else if (req[cand1_s]) begin
            win_idx_s = cand1_s;
        end else if (req[cand2_s]) begin
            win_idx_s = cand2_s;
        end else begin
            win_valid_s = 1'b0;
        end
    end

    // Next-state and next-output logic; pulses default low, held values default to current.
    always_comb begin
        state_next_s       = state_r;
        rr_ptr_next_s      = rr_ptr_r;
        wd_next_s          = wd_r;
        grant_next_s       = grant_r;
        done_next_s        = 3'b000;
        start_fetch_next_s = 1'b0;
        rac_next_s         = 1'b0;
        bsel_next_s        = bsel_r;
        tiles_next_s       = tiles_r;
        if (err_clr) begin
            terr_next_s = 1'b0;
        end else begin
            terr_next_s = terr_r;
        end

        case (state_r)
            IDLE: begin
                if (win_valid_s) begin
                    state_next_s       = ISSUE;
                    grant_next_s       = onehot3(win_idx_s);
                    bsel_next_s        = buf_code(win_idx_s);
                    tiles_next_s       = req_tiles_ctrl[win_idx_s];
                    rac_next_s         = req_rst_addr[win_idx_s];
                    start_fetch_next_s = 1'b1;
                    rr_ptr_next_s      = inc_mod3(win_idx_s);
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                state_next_s = WAIT;
                wd_next_s    = WD_ZERO;
            end
            WAIT: begin
                // A completion in the final watchdog cycle still counts as normal.
                if (fetch_done) begin
                    state_next_s = DONE;
                    done_next_s  = grant_r;
                end else if (wd_r >= WD_LAST) begin
                    state_next_s = DONE;
                    done_next_s  = grant_r;
                    terr_next_s  = 1'b1;
                    wd_next_s    = TIMEOUT_MAX;
                end else begin
                    wd_next_s = (wd_r == TIMEOUT_MAX) ? wd_r : (wd_r + WD_ONE);
                end
            end
            DONE: begin
                state_next_s = IDLE;
                grant_next_s = 3'b000;
            end
            default: begin
                state_next_s = IDLE;
                grant_next_s = 3'b000;
            end
        endcase

        busy_next_s = (state_next_s != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            rr_ptr_r      <= 2'd0;
            wd_r          <= WD_ZERO;
            grant_r       <= 3'b000;
            done_r        <= 3'b000;
            start_fetch_r <= 1'b0;
            rac_r         <= 1'b0;
            bsel_r        <= SEL_W;
            tiles_r       <= 1'b0;
            busy_r        <= 1'b0;
            terr_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            rr_ptr_r      <= rr_ptr_next_s;
            wd_r          <= wd_next_s;
            grant_r       <= grant_next_s;
            done_r        <= done_next_s;
            start_fetch_r <= start_fetch_next_s;
            rac_r         <= rac_next_s;
            bsel_r        <= bsel_next_s;
            tiles_r       <= tiles_next_s;
            busy_r        <= busy_next_s;
            terr_r        <= terr_next_s;
        end
    end

    assign grant              = grant_r;
    assign done               = done_r;
    assign start_fetch        = start_fetch_r;
    assign reset_addr_counter = rac_r;
    assign Buffer_Select      = bsel_r;
    assign Tiles_Control      = tiles_r;
    assign busy               = busy_r;
    assign timeout_err        = terr_r;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Scoreboard bench for fetch_arbiter: expected grants are queued as requests are
// driven and compared when the arbiter issues and completes each fetch.
module tb_fetch_arbiter;

    localparam int TMAX = 8;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] req_tiles_ctrl;
    logic [2:0] req_rst_addr;
    logic       fetch_done;
    logic       err_clr;
    logic [2:0] grant;
    logic [2:0] done;
    logic       start_fetch;
    logic       reset_addr_counter;
    logic [2:0] Buffer_Select;
    logic       Tiles_Control;
    logic       busy;
    logic       timeout_err;

    typedef struct packed {
        logic [2:0] grant;
        logic [2:0] bsel;
        logic       tiles;
        logic       rac;
        logic       terr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;

    fetch_arbiter #(
        .TIMEOUT_W   (16),
        .TIMEOUT_MAX (16'd8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req                (req),
        .req_tiles_ctrl     (req_tiles_ctrl),
        .req_rst_addr       (req_rst_addr),
        .fetch_done         (fetch_done),
        .err_clr            (err_clr),
        .grant              (grant),
        .done               (done),
        .start_fetch        (start_fetch),
        .reset_addr_counter (reset_addr_counter),
        .Buffer_Select      (Buffer_Select),
        .Tiles_Control      (Tiles_Control),
        .busy               (busy),
        .timeout_err        (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic tiles, input logic rac, input logic terr);
        exp_t e;
        e.grant = 3'(1 << idx);
        e.bsel  = 3'(idx);
        e.tiles = tiles;
        e.rac   = rac;
        e.terr  = terr;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_grant"}, grant, 3'b000);
        check_val({tag, "_done"}, done, 3'b000);
        check_val({tag, "_start"}, start_fetch, 1'b0);
        check_val({tag, "_rac"}, reset_addr_counter, 1'b0);
        check_val({tag, "_bsel"}, Buffer_Select, 3'd0);
        check_val({tag, "_tiles"}, Tiles_Control, 1'b0);
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_terr"}, timeout_err, 1'b0);
    endtask

    // done_after < 0: never complete (watchdog path); clr_at_to raises err_clr in the last WAIT cycle.
    task automatic run_fetch(input int done_after, input bit drop_req, input bit clr_at_to);
        int   n;
        exp_t e;
        n = 0;
        while (start_fetch !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("start_seen", start_fetch, 1'b1);
        check_val("latency", n, 1);
        if (exp_q.size() == 0) begin
            check_val("sb_nonempty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check_val("grant", grant, e.grant);
        check_val("onehot", $countones(grant), 1);
        check_val("bsel", Buffer_Select, e.bsel);
        check_val("tiles", Tiles_Control, e.tiles);
        check_val("rac", reset_addr_counter, e.rac);
        check_val("busy_issue", busy, 1'b1);
        if (drop_req) req = 3'b000;
        @(negedge clk);
        check_val("start_pulse", start_fetch, 1'b0);
        check_val("rac_pulse", reset_addr_counter, 1'b0);
        check_val("grant_wait", grant, e.grant);
        check_val("busy_wait", busy, 1'b1);
        if (done_after > 0) begin
            repeat (done_after - 1) @(negedge clk);
            check_val("done_early", done, 3'b000);
            fetch_done = 1'b1;
            @(negedge clk);
            fetch_done = 1'b0;
        end else begin
            repeat (TMAX - 1) @(negedge clk);
            check_val("to_done_early", done, 3'b000);
            check_val("to_terr_early", timeout_err, 1'b0);
            if (clr_at_to) err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
        end
        check_val("done", done, e.grant);
        check_val("terr", timeout_err, e.terr);
        check_val("grant_done", grant, e.grant);
        check_val("bsel_done", Buffer_Select, e.bsel);
        check_val("tiles_done", Tiles_Control, e.tiles);
        @(negedge clk);
        check_val("done_pulse", done, 3'b000);
        check_val("grant_idle", grant, 3'b000);
        check_val("busy_idle", busy, 1'b0);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b0;
        req            = 3'b000;
        req_tiles_ctrl = 3'b000;
        req_rst_addr   = 3'b000;
        fetch_done     = 1'b0;
        err_clr        = 1'b0;
        @(negedge clk);
        do_reset();
        check_reset_values("reset");

        // Spurious completion while idle
        fetch_done = 1'b1;
        @(negedge clk);
        fetch_done = 1'b0;
        check_reset_values("spurious");
        @(negedge clk);
        check_reset_values("spurious2");

        // Single request from bias, released mid-fetch
        push_exp(1, 1'b1, 1'b0, 1'b0);
        req            = 3'b010;
        req_tiles_ctrl = 3'b010;
        run_fetch(5, 1'b1, 1'b0);

        // Contention: all three held, expect 0,1,2,0
        do_reset();
        push_exp(0, 1'b1, 1'b0, 1'b0);
        push_exp(1, 1'b0, 1'b0, 1'b0);
        push_exp(2, 1'b1, 1'b0, 1'b0);
        push_exp(0, 1'b1, 1'b0, 1'b0);
        req            = 3'b111;
        req_tiles_ctrl = 3'b101;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) run_fetch(2, 1'b1, 1'b0);
            else        run_fetch(2, 1'b0, 1'b0);
        end
        req_tiles_ctrl = 3'b000;

        // Address-counter reset with inputs buffer
        do_reset();
        push_exp(2, 1'b0, 1'b1, 1'b0);
        req          = 3'b100;
        req_rst_addr = 3'b100;
        run_fetch(3, 1'b1, 1'b0);
        req_rst_addr = 3'b000;

        // Watchdog timeout; err_clr in the same cycle loses to the set
        push_exp(0, 1'b0, 1'b0, 1'b1);
        req = 3'b001;
        run_fetch(-1, 1'b1, 1'b1);
        check_val("terr_sticky", timeout_err, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_val("terr_clr", timeout_err, 1'b0);

        // Completion in the final watchdog cycle is a normal done
        push_exp(1, 1'b0, 1'b0, 1'b0);
        req = 3'b010;
        run_fetch(TMAX, 1'b1, 1'b0);

        // Reset during WAIT abandons the fetch
        req = 3'b001;
        @(negedge clk);
        check_val("rstw_start", start_fetch, 1'b1);
        check_val("rstw_grant", grant, 3'b001);
        req = 3'b000;
        repeat (2) @(negedge clk);
        check_val("rstw_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("rstw");
        fetch_done = 1'b1;
        @(negedge clk);
        fetch_done = 1'b0;
        check_reset_values("rstw_late");
        @(negedge clk);
        check_reset_values("rstw_late2");

        check_val("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
